// File: rtl/level0_pkg.sv
// Shared types and default key settings for the level0 serial-key lock.
// State encoding is used by the lock controller and visible to benches.
package level0_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        CHECK,
        UNLOCKED,
        FAIL,
        LOCKOUT
    } lock_state_t;

    localparam int          LEVEL0_WIDTH = 16;
    localparam logic [15:0] LEVEL0_KEY   = 16'h39C3;

endpackage

// File: rtl/level0_sync_edge.sv
// Synchronizes raw shift/d pins and emits a one-cycle pulse per shift rising edge.
// Latency: SYNC_STAGES cycles pin-to-pulse; d_sync aligned with shift_pulse.
// No backpressure: pins are free-running, every rising edge yields one pulse.
module level0_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic d,
    output logic shift_pulse,
    output logic d_sync
);

    logic [SYNC_STAGES-1:0] shift_chain;
    logic [SYNC_STAGES-1:0] d_chain;
    logic                   shift_q;
    logic [SYNC_STAGES:0]   primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_chain <= '0;
            d_chain     <= '0;
            shift_q     <= 1'b0;
            primed      <= '0;
        end else begin
            shift_chain <= {shift_chain[SYNC_STAGES-2:0], shift};
            d_chain     <= {d_chain[SYNC_STAGES-2:0], d};
            shift_q     <= shift_chain[SYNC_STAGES-1];
            primed      <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Pulses are held off until both the chain and shift_q carry post-reset
    // samples, so a pin already high at reset release is not seen as an edge.
    assign shift_pulse = primed[SYNC_STAGES] & shift_chain[SYNC_STAGES-1] & ~shift_q;
    assign d_sync      = d_chain[SYNC_STAGES-1];

endmodule

// File: rtl/level0_lock_ctrl.sv
// Serial-key attempt FSM: collects WIDTH bits MSB-first, checks KEY, drives LEDs, enforces lockout.
// Latency: last bit captured -> LEDs valid 2 cycles later; lockout lasts LOCKOUT_CYCLES cycles.
// No backpressure: shift pulses outside COLLECT/FAIL are dropped; clear is ignored in CHECK/LOCKOUT.
module level0_lock_ctrl
    import level0_pkg::*;
#(
    parameter int               WIDTH          = LEVEL0_WIDTH,
    parameter logic [WIDTH-1:0] KEY            = LEVEL0_KEY,
    parameter int               SYNC_STAGES    = 2,
    parameter int               MAX_FAILS      = 3,
    parameter int               LOCKOUT_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           shift,
    input  logic                           d,
    input  logic                           clear,
    output logic                           led1,
    output logic                           led2,
    output logic                           locked_out,
    output logic [$clog2(WIDTH+1)-1:0]     bit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int BCW = $clog2(WIDTH+1);
    localparam int FCW = $clog2(MAX_FAILS+1);
    localparam int TW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    lock_state_t      state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [BCW-1:0]   bit_count_nxt;
    logic [FCW-1:0]   fail_count_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic             shift_pulse;
    logic             d_sync;

    level0_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk         (clk),
        .rst         (rst),
        .shift       (shift),
        .d           (d),
        .shift_pulse (shift_pulse),
        .d_sync      (d_sync)
    );

    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        bit_count_nxt  = bit_count;
        fail_count_nxt = fail_count;
        timer_nxt      = timer;
        unique case (state)
            COLLECT: begin
                if (clear) begin
                    sr_nxt        = '0;
                    bit_count_nxt = '0;
                end else if (shift_pulse) begin
                    sr_nxt        = {sr[WIDTH-2:0], d_sync};
                    bit_count_nxt = bit_count + BCW'(1);
                    if (bit_count == BCW'(WIDTH-1)) state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (sr == KEY) begin
                    state_nxt      = UNLOCKED;
                    fail_count_nxt = '0;
                end else if (fail_count >= FCW'(MAX_FAILS-1)) begin
                    state_nxt      = LOCKOUT;
                    fail_count_nxt = FCW'(MAX_FAILS);
                    timer_nxt      = TW'(LOCKOUT_CYCLES-1);
                end else begin
                    state_nxt      = FAIL;
                    fail_count_nxt = fail_count + FCW'(1);
                end
            end
            UNLOCKED: begin
                if (clear) begin
                    state_nxt     = COLLECT;
                    sr_nxt        = '0;
                    bit_count_nxt = '0;
                end
            end
            FAIL: begin
                // A bit arriving in FAIL opens the next attempt as its bit 0.
                if (clear) begin
                    state_nxt     = COLLECT;
                    sr_nxt        = '0;
                    bit_count_nxt = '0;
                end else if (shift_pulse) begin
                    state_nxt     = COLLECT;
                    sr_nxt        = {{(WIDTH-1){1'b0}}, d_sync};
                    bit_count_nxt = BCW'(1);
                end
            end
            LOCKOUT: begin
                if (timer == '0) begin
                    state_nxt      = COLLECT;
                    sr_nxt         = '0;
                    bit_count_nxt  = '0;
                    fail_count_nxt = '0;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Indicators trail the state register by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            sr         <= '0;
            bit_count  <= '0;
            fail_count <= '0;
            timer      <= '0;
            led1       <= 1'b0;
            led2       <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            bit_count  <= bit_count_nxt;
            fail_count <= fail_count_nxt;
            timer      <= timer_nxt;
            led1       <= (state == UNLOCKED);
            led2       <= (state == FAIL) || (state == LOCKOUT);
            locked_out <= (state == LOCKOUT);
        end
    end

endmodule
